// File: rtl/task2_2_stim_seq.sv
// Stimulus sequencer for task2_2: sweeps {A,B,C} through 000..111 on button or timer steps
// and records the returned {X,Y} pairs into a 16-bit truth table.
module task2_2_stim_seq #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int STEP_CYCLES     = 100_000_000,
  parameter int SETTLE_CYCLES   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_step,
  input  logic        auto_en,
  input  logic        X,
  input  logic        Y,
  output logic        A,
  output logic        B,
  output logic        C,
  output logic [2:0]  idx,
  output logic [15:0] table_out,
  output logic        busy,
  output logic        done
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int STEP_W = $clog2(STEP_CYCLES);
  localparam int SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [DB_W-1:0]   DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [STEP_W-1:0] STEP_LAST   = STEP_W'(STEP_CYCLES - 1);
  localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_CAPTURE,
    S_WAIT,
    S_DONE
  } state_t;

  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic              db_level_q, db_level_d;
  logic              btn_pulse_q, btn_pulse_d;
  logic [STEP_W-1:0] pre_q, pre_d;
  logic              auto_tick;
  logic              step;

  state_t            state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic [2:0]        abc_q, abc_d;
  logic [15:0]       table_q, table_d;
  logic [SET_W-1:0]  settle_q, settle_d;

  // The new level is only accepted after it has been seen continuously for DEBOUNCE_CYCLES.
  always_comb begin
    sync1_d    = btn_step;
    sync2_d    = sync1_q;
    db_cnt_d   = '0;
    db_level_d = db_level_q;
    if (sync2_q != db_level_q) begin
      if (db_cnt_q == DB_LAST) begin
        db_level_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
    btn_pulse_d = db_level_d & ~db_level_q;
  end

  always_comb begin
    auto_tick = auto_en && (pre_q == STEP_LAST);
    if (!auto_en || auto_tick) begin
      pre_d = '0;
    end else begin
      pre_d = pre_q + STEP_W'(1);
    end
  end

  assign step = btn_pulse_q | auto_tick;

  // Steps are only honoured in IDLE/WAIT/DONE; anything arriving mid-sweep is dropped.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    abc_d    = abc_q;
    table_d  = table_q;
    settle_d = settle_q;
    case (state_q)
      S_IDLE: begin
        if (step) begin
          idx_d   = 3'd0;
          state_d = S_APPLY;
        end
      end
      S_APPLY: begin
        abc_d    = idx_q;
        settle_d = '0;
        state_d  = S_SETTLE;
      end
      S_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          state_d = S_CAPTURE;
        end else begin
          settle_d = settle_q + SET_W'(1);
        end
      end
      S_CAPTURE: begin
        table_d[{idx_q, 1'b0} +: 2] = {X, Y};
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (step) begin
          if (idx_q == 3'd7) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = S_APPLY;
          end
        end
      end
      S_DONE: begin
        if (step) begin
          table_d = '0;
          idx_d   = 3'd0;
          state_d = S_APPLY;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      db_cnt_q    <= '0;
      db_level_q  <= 1'b0;
      btn_pulse_q <= 1'b0;
      pre_q       <= '0;
      state_q     <= S_IDLE;
      idx_q       <= 3'd0;
      abc_q       <= 3'd0;
      table_q     <= '0;
      settle_q    <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      db_cnt_q    <= db_cnt_d;
      db_level_q  <= db_level_d;
      btn_pulse_q <= btn_pulse_d;
      pre_q       <= pre_d;
      state_q     <= state_d;
      idx_q       <= idx_d;
      abc_q       <= abc_d;
      table_q     <= table_d;
      settle_q    <= settle_d;
    end
  end

  // The visible index follows the registered stimulus so it always matches {A,B,C}.
  assign {A, B, C}  = abc_q;
  assign idx        = abc_q;
  assign table_out  = table_q;
  assign busy       = (state_q == S_APPLY) || (state_q == S_SETTLE) || (state_q == S_CAPTURE);
  assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_task2_2_stim_seq.sv
// Scoreboard bench for task2_2_stim_seq with a full-adder model standing in for task2_2.
// Expected sweep entries are queued as steps are issued and checked when each capture completes.
module tb_task2_2_stim_seq;

  localparam int DEB    = 4;
  localparam int STEP   = 20;
  localparam int SETTLE = 2;

  logic        clk;
  logic        rst;
  logic        btn_step;
  logic        auto_en;
  logic        X, Y;
  logic        A, B, C;
  logic [2:0]  idx;
  logic [15:0] table_out;
  logic        busy;
  logic        done;

  task2_2_stim_seq #(
    .DEBOUNCE_CYCLES(DEB),
    .STEP_CYCLES(STEP),
    .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_step(btn_step),
    .auto_en(auto_en),
    .X(X),
    .Y(Y),
    .A(A),
    .B(B),
    .C(C),
    .idx(idx),
    .table_out(table_out),
    .busy(busy),
    .done(done)
  );

  // Full adder as the downstream combinational block: X = carry, Y = sum.
  assign X = (A & B) | (A & C) | (B & C);
  assign Y = A ^ B ^ C;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [2:0]  idx;
    logic [15:0] tbl;
  } exp_t;

  typedef enum {M_IDLE, M_WAIT, M_DONE} mstate_t;

  exp_t        exp_q[$];
  exp_t        exp_e;
  mstate_t     m_state;
  logic [2:0]  m_idx;
  logic [15:0] m_tbl;
  logic        busy_prev;
  int          check_count;
  int          error_count;
  int          n_edges;

  function automatic logic [1:0] fa(input logic [2:0] v);
    return {(v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]), v[2] ^ v[1] ^ v[0]};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    check_count++;
    if (obs !== expv) begin
      error_count++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic pushExpected();
    exp_t e;
    m_tbl[{m_idx, 1'b0} +: 2] = fa(m_idx);
    e.idx = m_idx;
    e.tbl = m_tbl;
    exp_q.push_back(e);
  endtask

  // Reference sweep behaviour for one accepted step.
  task automatic modelStep();
    case (m_state)
      M_IDLE: begin
        m_idx   = 3'd0;
        pushExpected();
        m_state = M_WAIT;
      end
      M_WAIT: begin
        if (m_idx == 3'd7) begin
          m_state = M_DONE;
        end else begin
          m_idx = m_idx + 3'd1;
          pushExpected();
        end
      end
      default: begin
        m_tbl   = '0;
        m_idx   = 3'd0;
        pushExpected();
        m_state = M_WAIT;
      end
    endcase
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input int hold, input int gap);
    btn_step = 1'b1;
    waitCycles(hold);
    btn_step = 1'b0;
    waitCycles(gap);
  endtask

  // Counts rising edges until {A,B,C} changes, giving up after 100.
  task automatic measureChange(output int n);
    logic [2:0] prev;
    prev = {A, B, C};
    n = 0;
    while (n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if ({A, B, C} !== prev) break;
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      busy_prev = 1'b0;
    end else begin
      if (busy_prev && !busy) begin
        checkOutput("step_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          exp_e = exp_q.pop_front();
          checkOutput("sweep_idx", 32'(idx), 32'(exp_e.idx));
          checkOutput("sweep_abc", 32'({A, B, C}), 32'(exp_e.idx));
          checkOutput("sweep_table", 32'(table_out), 32'(exp_e.tbl));
        end
      end
      busy_prev = busy;
    end
  end

  initial begin
    check_count = 0;
    error_count = 0;
    busy_prev   = 1'b0;
    m_state     = M_IDLE;
    m_idx       = 3'd0;
    m_tbl       = '0;
    rst         = 1'b1;
    btn_step    = 1'b0;
    auto_en     = 1'b0;

    waitCycles(3);
    checkOutput("rst_abc", 32'({A, B, C}), 32'd0);
    checkOutput("rst_table", 32'(table_out), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    waitCycles(5);
    $display("[TB] manual sweep");

    for (int i = 0; i < 8; i++) begin
      modelStep();
      applyStimulus(10, 30);
    end
    checkOutput("manual_pending", 32'(exp_q.size()), 32'd0);
    checkOutput("manual_table", 32'(table_out), 32'hE994);
    checkOutput("manual_done_early", 32'(done), 32'd0);
    modelStep();
    applyStimulus(10, 30);
    checkOutput("manual_done", 32'(done), 32'd1);
    checkOutput("manual_done_busy", 32'(busy), 32'd0);
    checkOutput("manual_held_table", 32'(table_out), 32'(m_tbl));
    checkOutput("manual_held_idx", 32'(idx), 32'd7);

    $display("[TB] bounce and glitch");
    modelStep();
    for (int k = 0; k < 6; k++) begin
      btn_step = ~btn_step;
      waitCycles(2);
    end
    applyStimulus(10, 30);
    checkOutput("bounce_pending", 32'(exp_q.size()), 32'd0);
    checkOutput("bounce_done", 32'(done), 32'd0);
    applyStimulus(3, 30);
    checkOutput("glitch_pending", 32'(exp_q.size()), 32'd0);
    checkOutput("glitch_idx", 32'(idx), 32'(m_idx));

    $display("[TB] collision and drop");
    modelStep();
    auto_en = 1'b1;
    waitCycles(13);
    applyStimulus(10, 7);
    auto_en = 1'b0;
    waitCycles(20);
    checkOutput("collision_pending", 32'(exp_q.size()), 32'd0);
    checkOutput("collision_idx", 32'(idx), 32'(m_idx));
    modelStep();
    auto_en = 1'b1;
    waitCycles(15);
    applyStimulus(10, 5);
    auto_en = 1'b0;
    waitCycles(20);
    checkOutput("drop_pending", 32'(exp_q.size()), 32'd0);
    checkOutput("drop_idx", 32'(idx), 32'(m_idx));

    $display("[TB] auto re-enable and auto sweep");
    modelStep();
    auto_en = 1'b1;
    waitCycles(15);
    auto_en = 1'b0;
    waitCycles(1);
    auto_en = 1'b1;
    // Tick lands in the STEP-th enabled cycle, then one more edge to reach {A,B,C}.
    measureChange(n_edges);
    checkOutput("reenable_latency", 32'(n_edges), 32'(STEP + 1));
    for (int k = 0; k < 4; k++) begin
      modelStep();
      measureChange(n_edges);
      checkOutput("auto_period", 32'(n_edges), 32'(STEP));
    end
    modelStep();
    repeat (STEP) @(posedge clk);
    #1;
    checkOutput("auto_done", 32'(done), 32'd1);
    checkOutput("auto_done_busy", 32'(busy), 32'd0);
    checkOutput("auto_done_table", 32'(table_out), 32'(m_tbl));
    modelStep();
    measureChange(n_edges);
    checkOutput("auto_restart_period", 32'(n_edges), 32'(STEP));
    checkOutput("auto_restart_done", 32'(done), 32'd0);
    checkOutput("auto_restart_table", 32'(table_out), 32'h0);
    for (int k = 0; k < 4; k++) begin
      modelStep();
      measureChange(n_edges);
      checkOutput("auto_period2", 32'(n_edges), 32'(STEP));
    end

    $display("[TB] reset mid-settle");
    measureChange(n_edges);
    checkOutput("pre_reset_abc", 32'({A, B, C}), 32'd5);
    checkOutput("pre_reset_busy", 32'(busy), 32'd1);
    rst     = 1'b1;
    auto_en = 1'b0;
    #1;
    checkOutput("abort_abc", 32'({A, B, C}), 32'd0);
    checkOutput("abort_idx", 32'(idx), 32'd0);
    checkOutput("abort_table", 32'(table_out), 32'h0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    waitCycles(3);
    rst     = 1'b0;
    m_state = M_IDLE;
    m_idx   = 3'd0;
    m_tbl   = '0;
    waitCycles(10);
    checkOutput("final_pending", 32'(exp_q.size()), 32'd0);
    checkOutput("final_idle_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
